// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared defaults, kernel PID and FSM state type for the RR scheduler
// Contents:
//   DEFAULT_NPROC / DEFAULT_PID_W / DEFAULT_QUANTUM : parameter defaults
//   KERNEL_PID                                      : PID never scheduled
//   sched_state_e                                   : IDLE / PICK / SWITCH / RUN
package rr_sched_pkg;

   localparam int DEFAULT_NPROC   = 32;
   localparam int DEFAULT_PID_W   = 5;
   localparam int DEFAULT_QUANTUM = 62;
   localparam int KERNEL_PID      = 0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PICK   = 2'd1,
      S_SWITCH = 2'd2,
      S_RUN    = 2'd3
   } sched_state_e;

endpackage

// File: rtl/rr_process_scheduler_if.sv
// rtl/rr_process_scheduler_if.sv - control/handshake bundle between scheduler and its environment
// Signals:
//   enable, ready_set, ready_clr, ready_pid, yield, stall, sw_ack : into scheduler
//   sw_req, sw_pid, run_pid, running                              : out of scheduler
// Modports: master (environment/datapath side), slave (scheduler side).
interface rr_process_scheduler_if
   import rr_sched_pkg::*;
#(
   parameter int PID_W = DEFAULT_PID_W
);
   logic             enable;
   logic             ready_set;
   logic             ready_clr;
   logic [PID_W-1:0] ready_pid;
   logic             yield;
   logic             stall;
   logic             sw_req;
   logic [PID_W-1:0] sw_pid;
   logic             sw_ack;
   logic [PID_W-1:0] run_pid;
   logic             running;

   modport master (
      output enable, ready_set, ready_clr, ready_pid, yield, stall, sw_ack,
      input  sw_req, sw_pid, run_pid, running
   );

   modport slave (
      input  enable, ready_set, ready_clr, ready_pid, yield, stall, sw_ack,
      output sw_req, sw_pid, run_pid, running
   );
endinterface

// File: rtl/rr_next_pid.sv
// rtl/rr_next_pid.sv - combinational circular search for the next ready PID
// Ports:
//   mask_i  in  NPROC  ready mask (bit 0 = kernel, never returned)
//   start_i in  PID_W  current PID; search begins at start_i+1
//   found_o out 1      a ready PID exists in 1..NPROC-1
//   pid_o   out PID_W  first ready PID in order start+1 .. NPROC-1, 1 .. start
module rr_next_pid
   import rr_sched_pkg::*;
#(
   parameter int NPROC = DEFAULT_NPROC,
   parameter int PID_W = DEFAULT_PID_W
) (
   input  logic [NPROC-1:0] mask_i,
   input  logic [PID_W-1:0] start_i,
   output logic             found_o,
   output logic [PID_W-1:0] pid_o
);

   logic [PID_W:0]   sum;
   logic [PID_W-1:0] cand;

   // Offsets 1..NPROC-1 walk the user PIDs once; wrapping subtracts NPROC-1
   // so the sequence skips slot 0 and ends on start_i itself.
   always_comb begin
      found_o = 1'b0;
      pid_o   = '0;
      sum     = '0;
      cand    = '0;
      for (int k = 1; k < NPROC; k++) begin
         sum  = {1'b0, start_i} + (PID_W+1)'(k);
         cand = (sum > (PID_W+1)'(NPROC-1)) ? PID_W'(sum - (PID_W+1)'(NPROC-1))
                                            : PID_W'(sum);
         if (!found_o && mask_i[cand]) begin
            found_o = 1'b1;
            pid_o   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_process_scheduler.sv
// rtl/rr_process_scheduler.sv - round-robin process scheduler with context-switch handshake
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    slave modport of rr_process_scheduler_if:
//          enable/ready_set/ready_clr/ready_pid/yield/stall/sw_ack in,
//          sw_req/sw_pid/run_pid/running out
// Build option: RR_PREEMPT_EN enables the quantum counter and time-slice
// preemption; without it scheduling is cooperative and stall is ignored.
module rr_process_scheduler
   import rr_sched_pkg::*;
#(
   parameter int NPROC   = DEFAULT_NPROC,
   parameter int PID_W   = DEFAULT_PID_W,
   parameter int QUANTUM = DEFAULT_QUANTUM
) (
   input  logic                  clk,
   input  logic                  reset,
   rr_process_scheduler_if.slave bus
);

   sched_state_e     state_q, state_d;
   logic [NPROC-1:0] mask_q, mask_d;
   logic [PID_W-1:0] cur_q, cur_d;
   logic [PID_W-1:0] sw_pid_q, sw_pid_d;
   logic             nx_found;
   logic [PID_W-1:0] nx_pid;

`ifdef RR_PREEMPT_EN
   localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_last;
   assign at_last = (cnt_q == CNT_W'(QUANTUM-1));
`else
   localparam int unused_quantum = QUANTUM;
   logic unused_stall;
   assign unused_stall = bus.stall;
`endif

   rr_next_pid #(.NPROC(NPROC), .PID_W(PID_W)) u_next_pid (
      .mask_i  (mask_q),
      .start_i (cur_q),
      .found_o (nx_found),
      .pid_o   (nx_pid)
   );

   // Clear is applied after set so a simultaneous set+clr leaves the bit clear.
   always_comb begin
      mask_d = mask_q;
      if (bus.ready_set && int'(bus.ready_pid) != KERNEL_PID && int'(bus.ready_pid) < NPROC)
         mask_d[bus.ready_pid] = 1'b1;
      if (bus.ready_clr && int'(bus.ready_pid) < NPROC)
         mask_d[bus.ready_pid] = 1'b0;
   end

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      sw_pid_d = sw_pid_q;
`ifdef RR_PREEMPT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.enable && |mask_q[NPROC-1:1])
               state_d = S_PICK;
         end
         S_PICK: begin
            if (!nx_found) begin
               state_d = S_IDLE;
            end else if (nx_pid == cur_q) begin
               // Only the current PID is ready: restart its slice, no switch.
               state_d = S_RUN;
`ifdef RR_PREEMPT_EN
               cnt_d   = '0;
`endif
            end else begin
               sw_pid_d = nx_pid;
               state_d  = S_SWITCH;
            end
         end
         S_SWITCH: begin
            // enable is only honoured once the datapath acknowledges.
            if (bus.sw_ack) begin
               cur_d   = sw_pid_q;
`ifdef RR_PREEMPT_EN
               cnt_d   = '0;
`endif
               state_d = bus.enable ? S_RUN : S_IDLE;
            end
         end
         S_RUN: begin
            if (!bus.enable)
               state_d = S_IDLE;
            else if (bus.yield)
               state_d = S_PICK;
            else if (!mask_q[cur_q])
               state_d = S_PICK;
`ifdef RR_PREEMPT_EN
            else if (!bus.stall && at_last)
               state_d = S_PICK;
            // Saturate at QUANTUM-1 so the counter never wraps.
            if (!bus.stall && !at_last)
               cnt_d = cnt_q + CNT_W'(1);
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         cur_q    <= '0;
         sw_pid_q <= '0;
`ifdef RR_PREEMPT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         cur_q    <= cur_d;
         sw_pid_q <= sw_pid_d;
`ifdef RR_PREEMPT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // All outputs decode from registers, so reset clears them immediately.
   assign bus.running = (state_q == S_RUN);
   assign bus.run_pid = (state_q == S_RUN) ? cur_q : '0;
   assign bus.sw_req  = (state_q == S_SWITCH);
   assign bus.sw_pid  = sw_pid_q;

endmodule

// File: tb/tb_rr_process_scheduler.sv
// tb/tb_rr_process_scheduler.sv - self-checking bench for rr_process_scheduler
module tb_rr_process_scheduler;
   import rr_sched_pkg::*;

   localparam int NP = 32;
   localparam int PW = 5;
   localparam int QT = 62;
`ifdef RR_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif
   localparam int P_IDLE = 0, P_PICK = 1, P_SWITCH = 2, P_RUN = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rr_process_scheduler_if #(.PID_W(PW)) sif ();

   rr_process_scheduler #(.NPROC(NP), .PID_W(PW), .QUANTUM(QT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference model: phase, ready set, owner and remaining slice length.
   int m_ph = P_IDLE;
   int m_cur = 0;
   int m_left = QT;
   int m_swpid = 0;
   bit m_ready[NP];

   function automatic int next_ready(input int from);
      int p;
      p = from;
      for (int s = 0; s < NP-1; s++) begin
         p = (p >= NP-1) ? 1 : p + 1;
         if (m_ready[p]) return p;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ph = P_IDLE; m_cur = 0; m_left = QT; m_swpid = 0;
      for (int i = 0; i < NP; i++) m_ready[i] = 1'b0;
   endtask

   task automatic model_step();
      bit any;
      int n;
      int p;
      case (m_ph)
         P_IDLE: begin
            any = 1'b0;
            for (int i = 1; i < NP; i++) any |= m_ready[i];
            if (sif.enable && any) m_ph = P_PICK;
         end
         P_PICK: begin
            n = next_ready(m_cur);
            if (n < 0) m_ph = P_IDLE;
            else if (n == m_cur) begin m_left = QT; m_ph = P_RUN; end
            else begin m_swpid = n; m_ph = P_SWITCH; end
         end
         P_SWITCH: begin
            if (sif.sw_ack) begin
               m_cur = m_swpid; m_left = QT;
               m_ph = sif.enable ? P_RUN : P_IDLE;
            end
         end
         default: begin
            if (!sif.enable) m_ph = P_IDLE;
            else if (sif.yield) m_ph = P_PICK;
            else if (!m_ready[m_cur]) m_ph = P_PICK;
            else if (PREEMPT && !sif.stall) begin
               if (m_left == 1) m_ph = P_PICK;
               else m_left = m_left - 1;
            end
         end
      endcase
      p = int'(sif.ready_pid);
      if (sif.ready_set && p != 0) m_ready[p] = 1'b1;
      if (sif.ready_clr) m_ready[p] = 1'b0;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("cmp_running", int'(sif.running), int'(m_ph == P_RUN));
         chk("cmp_run_pid", int'(sif.run_pid), (m_ph == P_RUN) ? m_cur : 0);
         chk("cmp_sw_req", int'(sif.sw_req), int'(m_ph == P_SWITCH));
         if (m_ph == P_SWITCH) chk("cmp_sw_pid", int'(sif.sw_pid), m_swpid);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_rdy(input int p);
      sif.ready_set = 1'b1; sif.ready_pid = PW'(p);
      tick();
      sif.ready_set = 1'b0;
   endtask

   task automatic clr_rdy(input int p);
      sif.ready_clr = 1'b1; sif.ready_pid = PW'(p);
      tick();
      sif.ready_clr = 1'b0;
   endtask

   task automatic ack_sw();
      sif.sw_ack = 1'b1;
      tick();
      sif.sw_ack = 1'b0;
   endtask

   task automatic do_yield();
      sif.yield = 1'b1;
      tick();
      sif.yield = 1'b0;
   endtask

   task automatic wait_sw(input string name, input int exp);
      int n;
      n = 0;
      while (!sif.sw_req && n < 20) begin tick(); n++; end
      chk({name, "_req"}, int'(sif.sw_req), 1);
      chk(name, int'(sif.sw_pid), exp);
   endtask

   task automatic count_run(output int n, input bit stall_first10);
      n = 0;
      while (sif.running && n < 300) begin
         n++;
         if (stall_first10) sif.stall = (n <= 10);
         tick();
      end
      sif.stall = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      sif.enable = 1'b0; sif.ready_set = 1'b0; sif.ready_clr = 1'b0;
      sif.ready_pid = '0; sif.yield = 1'b0; sif.stall = 1'b0; sif.sw_ack = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("rst_sw_req", int'(sif.sw_req), 0);
      chk("rst_sw_pid", int'(sif.sw_pid), 0);
      chk("rst_run_pid", int'(sif.run_pid), 0);
      chk("rst_running", int'(sif.running), 0);

      // First schedule: PIDs 3 and 7 ready, 3 wins from cur=0.
      sif.enable = 1'b1;
      set_rdy(3);
      set_rdy(7);
      wait_sw("first_sw", 3);
      tick();
      chk("hold_req", int'(sif.sw_req), 1);
      chk("hold_pid", int'(sif.sw_pid), 3);
      ack_sw();
      chk("run3_running", int'(sif.running), 1);
      chk("run3_pid", int'(sif.run_pid), 3);
      chk("run3_req_drop", int'(sif.sw_req), 0);

`ifdef RR_PREEMPT_EN
      count_run(n, 1'b0);
      chk("slice_len", n, 62);
      wait_sw("expire_to_7", 7);
      ack_sw();
      count_run(n, 1'b1);
      chk("stall_slice_len", n, 72);
      wait_sw("wrap_to_3", 3);
      ack_sw();
`else
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         sif.stall = (i % 3 == 0);
         tick();
         if (!(sif.running && sif.run_pid == 3 && !sif.sw_req)) bad++;
      end
      sif.stall = 1'b0;
      chk("coop_hold", bad, 0);
      do_yield();
      wait_sw("yield_to_7", 7);
      ack_sw();
      do_yield();
      wait_sw("yield_to_3", 3);
      ack_sw();
`endif

      // Block the running process via ready_clr.
      do_yield();
      wait_sw("yield_7", 7);
      ack_sw();
      chk("run7_pid", int'(sif.run_pid), 7);
      clr_rdy(7);
      chk("clr_still_run", int'(sif.running), 1);
      tick();
      chk("clr_pick", int'(sif.running), 0);
      wait_sw("after_clr", 3);
      ack_sw();
      chk("back3_pid", int'(sif.run_pid), 3);

      // Simultaneous set+clr on PID 9 leaves it clear: yield re-picks 3 with no switch.
      sif.ready_set = 1'b1; sif.ready_clr = 1'b1; sif.ready_pid = PW'(9);
      tick();
      sif.ready_set = 1'b0; sif.ready_clr = 1'b0;
      do_yield();
      chk("self_pick_req", int'(sif.sw_req), 0);
      chk("self_pick_running", int'(sif.running), 0);
      tick();
      chk("self_run", int'(sif.running), 1);
      chk("self_run_pid", int'(sif.run_pid), 3);
      chk("self_run_req", int'(sif.sw_req), 0);

      // enable dropped mid-handshake: hold until ack, then IDLE.
      set_rdy(7);
      do_yield();
      wait_sw("drop_en_sw", 7);
      sif.enable = 1'b0;
      bad = 0;
      repeat (20) begin
         tick();
         if (!(sif.sw_req && sif.sw_pid == 7)) bad++;
      end
      chk("held_handshake", bad, 0);
      ack_sw();
      chk("drop_req", int'(sif.sw_req), 0);
      chk("drop_running", int'(sif.running), 0);
      chk("drop_run_pid", int'(sif.run_pid), 0);
      tick();
      chk("idle_stays", int'(sif.running), 0);

      // Reset in the middle of a switch.
      sif.enable = 1'b1;
      tick();
      wait_sw("resume_to_3", 3);
      #2 reset = 1'b1;
      #1;
      chk("arst_sw_req", int'(sif.sw_req), 0);
      chk("arst_sw_pid", int'(sif.sw_pid), 0);
      chk("arst_run_pid", int'(sif.run_pid), 0);
      chk("arst_running", int'(sif.running), 0);
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (3) tick();
      chk("post_rst_running", int'(sif.running), 0);
      chk("post_rst_req", int'(sif.sw_req), 0);

`ifdef RR_PREEMPT_EN
      // Lone ready PID: expiry re-runs it without a switch request.
      set_rdy(5);
      wait_sw("only5", 5);
      ack_sw();
      count_run(n, 1'b0);
      chk("only5_slice", n, 62);
      chk("only5_pick_req", int'(sif.sw_req), 0);
      tick();
      chk("only5_rerun", int'(sif.running), 1);
      chk("only5_rerun_pid", int'(sif.run_pid), 5);
      chk("only5_rerun_req", int'(sif.sw_req), 0);
      count_run(n, 1'b0);
      chk("only5_slice2", n, 62);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
